// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver state encoding,
// oversampling ratio and the baud divisor / voting helpers.
package uart_pkg;

  // Samples taken per bit period.
  localparam int OVERSAMPLE = 16;

  // Receiver states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
  endfunction

  // Two-out-of-three vote used to reject noise around the bit centre.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, where DIV is
// CLK_HZ / (BAUD * OVERSAMPLE) rounded to nearest.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 25175000,
  parameter int BAUD   = 115200
) (
  input  logic clk25,
  input  logic rst,
  output logic tick
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  // A zero divisor means the clock is too slow for the requested baud rate.
  if (DIV < 1) begin : g_div_check
    $error("uart_baud_tick: divisor is zero, CLK_HZ too low for BAUD");
  end

  logic [CW-1:0] cnt;

  // Free-running divider counting 0 .. DIV-1, then wrapping.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, recovers frames with 16x oversampling
// and 3-sample majority voting, and hands bytes out on a valid/ready register.
// Framing errors and overruns are reported as one-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 25175000,
  parameter int BAUD   = 115200
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  logic       rx_meta;
  logic       rxs;
  logic       tick;

  rx_state_t  state,  state_nxt;
  logic [3:0] scnt,   scnt_nxt;
  logic [2:0] bitn,   bitn_nxt;
  logic [7:0] shreg,  shreg_nxt;
  logic       s7,     s7_nxt;
  logic       s8,     s8_nxt;
  logic       maj;
  logic       deliver;
  logic       fe_set;

  // Two-flop synchroniser; both stages reset to the idle (high) line level.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so each flop takes the pre-edge value of
      // its source; blocking here would collapse the chain into a single stage.
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  uart_baud_tick #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_tick (
    .clk25 (clk25),
    .rst   (rst),
    .tick  (tick)
  );

  // Frame state and datapath registers.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      scnt  <= '0;
      bitn  <= '0;
      // NOTE: shreg is an ordinary register, not a memory, so it is reset with
      // everything else; a frame cut by reset leaves no stale bits behind.
      shreg <= '0;
      s7    <= 1'b0;
      s8    <= 1'b0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
      bitn  <= bitn_nxt;
      shreg <= shreg_nxt;
      s7    <= s7_nxt;
      s8    <= s8_nxt;
    end
  end

  // Next-state and sampling decisions, evaluated only on oversample ticks.
  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    state_nxt = state;
    scnt_nxt  = scnt;
    bitn_nxt  = bitn;
    shreg_nxt = shreg;
    s7_nxt    = s7;
    s8_nxt    = s8;
    deliver   = 1'b0;
    fe_set    = 1'b0;
    maj       = majority3(s7, s8, rxs);

    if (tick) begin
      // Capture the two early votes; the third is rxs itself at scnt 9.
      if (state == START || state == DATA || state == STOP) begin
        scnt_nxt = scnt + 4'd1;
        if (scnt == 4'd7) s7_nxt = rxs;
        if (scnt == 4'd8) s8_nxt = rxs;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            scnt_nxt  = '0;
            state_nxt = START;
          end
        end

        START: begin
          if (scnt == 4'd9 && maj) begin
            state_nxt = IDLE;           // glitch, not a real start bit
          end else if (scnt == 4'd15) begin
            state_nxt = DATA;
            bitn_nxt  = '0;
          end
        end

        DATA: begin
          if (scnt == 4'd9) begin
            shreg_nxt = {maj, shreg[7:1]};  // LSB arrives first
          end
          if (scnt == 4'd15) begin
            if (bitn == 3'd7) begin
              state_nxt = STOP;
            end else begin
              bitn_nxt = bitn + 3'd1;
            end
          end
        end

        STOP: begin
          if (scnt == 4'd9) begin
            if (maj) begin
              deliver   = 1'b1;        // don't wait out the stop bit
              state_nxt = IDLE;
            end else begin
              fe_set    = 1'b1;
              state_nxt = BREAK;
            end
          end
        end

        BREAK: begin
          if (rxs) state_nxt = IDLE;
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // One-entry output buffer with overrun detection and registered status pulses.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_set;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;          // buffer still full: new byte is dropped
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner
// sequences (overrun, glitch, break, reset mid-frame, default divisor) and a
// randomized frame stream compared against a frame-level reference model.
module tb_uart_rx;

  localparam int TB_CLK_HZ = 1600000;
  localparam int TB_BAUD   = 100000;

  logic       clk25 = 1'b0;
  logic       rst   = 1'b1;
  logic       rx    = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  logic       rx_def    = 1'b1;
  logic       ready_def = 1'b1;
  logic [7:0] data_def;
  logic       valid_def;
  logic       fe_def;
  logic       ov_def;

  always #5 clk25 = ~clk25;

  uart_rx #(
    .CLK_HZ (TB_CLK_HZ),
    .BAUD   (TB_BAUD)
  ) dut (
    .clk25     (clk25),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  uart_rx dut_def (
    .clk25     (clk25),
    .rst       (rst),
    .rx        (rx_def),
    .data      (data_def),
    .valid     (valid_def),
    .ready     (ready_def),
    .frame_err (fe_def),
    .overrun   (ov_def)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Event log gathered on the falling edge, away from the active edge.
  logic [7:0] got_q[$];
  logic [7:0] def_got_q[$];
  int fe_cnt = 0, ov_cnt = 0, valid_cycles = 0;
  int def_fe_cnt = 0, def_ov_cnt = 0;

  always @(negedge clk25) begin
    if (!rst) begin
      if (valid && ready) got_q.push_back(data);
      if (frame_err)      fe_cnt++;
      if (overrun)        ov_cnt++;
      if (valid)          valid_cycles++;
      if (valid_def && ready_def) def_got_q.push_back(data_def);
      if (fe_def)         def_fe_cnt++;
      if (ov_def)         def_ov_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Wait n clocks; inputs change 1 time unit after the rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic drive_line(input logic v, input bit on_def);
    if (on_def) rx_def = v;
    else        rx     = v;
  endtask

  // One 8N1 frame; cpb2 is the bit period in half clocks (32 = 16 clocks).
  // The line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input int cpb2, input logic stop, input bit on_def);
    logic [9:0] bits;
    int total;
    bits  = {stop, b, 1'b0};
    total = (10 * cpb2) / 2;
    for (int c = 0; c < total; c++) begin
      drive_line(bits[(2 * c) / cpb2], on_def);
      cycles(1);
    end
  endtask

  task automatic idle_line(input int n);
    rx = 1'b1;
    cycles(n);
  endtask

  typedef struct {
    logic [7:0] b;
    int         cpb2;
    logic       stop;
    int         exp_bytes;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  logic [7:0] exp_q[$];
  int base_got, base_fe, base_ov, base_vc, exp_fe, n_rand;

  initial begin
    vecs[0] = '{b: 8'h55, cpb2: 32, stop: 1'b1, exp_bytes: 1, exp_fe: 0};
    vecs[1] = '{b: 8'h00, cpb2: 31, stop: 1'b1, exp_bytes: 1, exp_fe: 0};
    vecs[2] = '{b: 8'h00, cpb2: 33, stop: 1'b1, exp_bytes: 1, exp_fe: 0};
    vecs[3] = '{b: 8'hFF, cpb2: 32, stop: 1'b1, exp_bytes: 1, exp_fe: 0};
    vecs[4] = '{b: 8'hA5, cpb2: 33, stop: 1'b1, exp_bytes: 1, exp_fe: 0};
    vecs[5] = '{b: 8'hC3, cpb2: 32, stop: 1'b0, exp_bytes: 0, exp_fe: 1};

    // Reset state.
    repeat (3) @(negedge clk25);
    check("reset data",      32'(data),      32'h0);
    check("reset valid",     32'(valid),     32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset overrun",   32'(overrun),   32'h0);
    @(posedge clk25);
    #1 rst = 1'b0;
    idle_line(20);

    // Table-driven frames with ready held high.
    ready = 1'b1;
    foreach (vecs[i]) begin
      base_got = got_q.size();
      base_fe  = fe_cnt;
      base_vc  = valid_cycles;
      base_ov  = ov_cnt;
      send_frame(vecs[i].b, vecs[i].cpb2, vecs[i].stop, 1'b0);
      idle_line(40);
      check($sformatf("vec%0d bytes", i), 32'(got_q.size() - base_got), 32'(vecs[i].exp_bytes));
      if (vecs[i].exp_bytes > 0 && got_q.size() > 0)
        check($sformatf("vec%0d data", i), 32'(got_q[got_q.size() - 1]), 32'(vecs[i].b));
      check($sformatf("vec%0d valid cycles", i), 32'(valid_cycles - base_vc), 32'(vecs[i].exp_bytes));
      check($sformatf("vec%0d frame_err", i), 32'(fe_cnt - base_fe), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d overrun", i), 32'(ov_cnt - base_ov), 32'h0);
    end

    // Back-to-back frames with ready low: first byte held, second overruns.
    ready    = 1'b0;
    base_got = got_q.size();
    base_ov  = ov_cnt;
    base_fe  = fe_cnt;
    send_frame(8'hA5, 32, 1'b1, 1'b0);
    send_frame(8'h3C, 32, 1'b1, 1'b0);
    idle_line(40);
    check("ovr valid held", 32'(valid), 32'h1);
    check("ovr data held",  32'(data),  32'hA5);
    check("ovr pulse",      32'(ov_cnt - base_ov), 32'h1);
    check("ovr no fe",      32'(fe_cnt - base_fe), 32'h0);
    check("ovr none taken", 32'(got_q.size() - base_got), 32'h0);
    ready = 1'b1;
    cycles(5);
    check("ovr accepted once", 32'(got_q.size() - base_got), 32'h1);
    if (got_q.size() > 0) check("ovr accepted byte", 32'(got_q[got_q.size() - 1]), 32'hA5);
    check("ovr valid falls", 32'(valid), 32'h0);

    // Short low glitch on an idle line must be ignored.
    base_got = got_q.size();
    base_fe  = fe_cnt;
    base_vc  = valid_cycles;
    rx = 1'b0;
    cycles(4);
    idle_line(40);
    check("glitch no valid", 32'(valid_cycles - base_vc), 32'h0);
    check("glitch no fe",    32'(fe_cnt - base_fe), 32'h0);
    send_frame(8'h3C, 32, 1'b1, 1'b0);
    idle_line(40);
    check("post-glitch bytes", 32'(got_q.size() - base_got), 32'h1);
    if (got_q.size() > 0) check("post-glitch data", 32'(got_q[got_q.size() - 1]), 32'h3C);

    // Bad stop bit followed by a long break, then a clean frame.
    base_got = got_q.size();
    base_fe  = fe_cnt;
    base_vc  = valid_cycles;
    send_frame(8'h81, 32, 1'b0, 1'b0);
    cycles(40 * 16);
    check("break fe once",   32'(fe_cnt - base_fe), 32'h1);
    check("break no valid",  32'(valid_cycles - base_vc), 32'h0);
    idle_line(32);
    send_frame(8'h7E, 32, 1'b1, 1'b0);
    idle_line(40);
    check("after break fe",    32'(fe_cnt - base_fe), 32'h1);
    check("after break bytes", 32'(got_q.size() - base_got), 32'h1);
    if (got_q.size() > 0) check("after break data", 32'(got_q[got_q.size() - 1]), 32'h7E);

    // Reset during data bit 4 with a byte pending on the output.
    ready = 1'b0;
    send_frame(8'h5A, 32, 1'b1, 1'b0);
    idle_line(20);
    check("pre-reset valid", 32'(valid), 32'h1);
    base_got = got_q.size();
    fork
      send_frame(8'hFF, 32, 1'b1, 1'b0);
      begin
        repeat (16 * 5 + 4) @(posedge clk25);
        #3 rst = 1'b1;
        #1;
        check("mid-reset data",      32'(data),      32'h0);
        check("mid-reset valid",     32'(valid),     32'h0);
        check("mid-reset frame_err", 32'(frame_err), 32'h0);
        check("mid-reset overrun",   32'(overrun),   32'h0);
        @(posedge clk25);
        #1 rst = 1'b0;
      end
    join
    ready = 1'b1;
    idle_line(40);
    check("cut frame lost", 32'(got_q.size() - base_got), 32'h0);
    send_frame(8'h12, 32, 1'b1, 1'b0);
    idle_line(40);
    check("post-reset bytes", 32'(got_q.size() - base_got), 32'h1);
    if (got_q.size() > 0) check("post-reset data", 32'(got_q[got_q.size() - 1]), 32'h12);

    // Default parameters: DIV = 14, 224 clocks per bit.
    send_frame(8'hA7, 448, 1'b1, 1'b1);
    rx_def = 1'b1;
    cycles(400);
    check("default bytes", 32'(def_got_q.size()), 32'h1);
    if (def_got_q.size() > 0) check("default data", 32'(def_got_q[0]), 32'hA7);
    check("default fe",      32'(def_fe_cnt), 32'h0);
    check("default overrun", 32'(def_ov_cnt), 32'h0);

    // Random frames: model says good stop -> byte in order, bad stop -> one
    // frame error and no byte.
    base_got = got_q.size();
    base_fe  = fe_cnt;
    base_ov  = ov_cnt;
    exp_fe   = 0;
    n_rand   = 40;
    for (int i = 0; i < n_rand; i++) begin
      logic [7:0] b;
      int         cpb2;
      logic       stop;
      b    = 8'($urandom_range(0, 255));
      cpb2 = 31 + int'($urandom_range(0, 2));
      stop = !(cpb2 != 31 && $urandom_range(0, 7) == 0);
      if (stop) exp_q.push_back(b);
      else      exp_fe++;
      send_frame(b, cpb2, stop, 1'b0);
      idle_line(int'($urandom_range(2, 20)));
    end
    idle_line(60);
    check("rand byte count", 32'(got_q.size() - base_got), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (base_got + i < got_q.size())
        check($sformatf("rand byte %0d", i), 32'(got_q[base_got + i]), 32'(exp_q[i]));
    end
    check("rand frame_err", 32'(fe_cnt - base_fe), 32'(exp_fe));
    check("rand overrun",   32'(ov_cnt - base_ov), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
